dma_desc_fetch: RTL and testbench

Descriptor fetch engine at the head of the DMA pipeline. Walks a linked list of 32-byte descriptors in host memory via an AVMM burst-read master, assembles each into a 256-bit word, and pushes it into the descriptor processor's input FIFO. Pushes are throttled by that FIFO's almost-full flag. Runs from a CSR doorbell until end-of-chain, an unowned descriptor, an error, or the run bit drops.

---
 rtl/dma_desc_pkg.sv | 35 +++
 rtl/dma_desc_beat_asm.sv | 45 ++++
 rtl/dma_desc_fetch.sv | 175 +++++++++++++++++
 tb/tb_dma_desc_fetch.sv | 385 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_desc_pkg.sv
// Shared descriptor layout and fetch-engine state encoding for the DMA descriptor path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dma_desc_pkg;

    // One descriptor is a fixed 8-beat burst of 32-bit words, 32 bytes in host memory.
    localparam int DESC_WORDS = 8;
    localparam int DESC_BYTES = 32;

    // Word indices inside the assembled 256-bit descriptor (word i at bits [32i+31:32i]).
    localparam int W_SRC  = 0;
    localparam int W_DST  = 1;
    localparam int W_LEN  = 2;
    localparam int W_CTRL = 3;
    localparam int W_NEXT = 4;

    // Bit positions inside the control word.
    localparam int OWNED  = 31;
    localparam int EOC    = 1;
    localparam int IRQ_EN = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_DATA,
        ST_CHECK,
        ST_PUSH
    } fetch_state_e;

    // Extract descriptor word idx from an assembled descriptor.
    function automatic logic [31:0] desc_word(input logic [255:0] desc, input int idx);
        return desc[32*idx +: 32];
    endfunction

endpackage

// File: rtl/dma_desc_beat_asm.sv
// Collects the eight 32-bit read beats of one descriptor burst into a 256-bit word.
// Latency: done_o is combinational with the final beat; the full word is visible next cycle.
// Backpressure: none; every beat presented while enabled is stored.
module dma_desc_beat_asm
    import dma_desc_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         clr_i,
    input  logic         beat_vld_i,
    input  logic [31:0]  beat_dat_i,
    output logic [255:0] desc_o,
    output logic         done_o
);

    logic [2:0]   beat_q, beat_d;
    logic [255:0] desc_q, desc_d;

    // Slot write addressed by the beat counter; clear restarts at slot 0 for a new burst.
    always_comb begin
        beat_d = beat_q;
        desc_d = desc_q;
        if (clr_i) begin
            beat_d = '0;
        end else if (beat_vld_i) begin
            desc_d[32*beat_q +: 32] = beat_dat_i;
            beat_d                  = beat_q + 3'd1;
        end
    end

    // Beat counter and descriptor storage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            beat_q <= '0;
            desc_q <= '0;
        end else begin
            beat_q <= beat_d;
            desc_q <= desc_d;
        end
    end

    assign desc_o = desc_q;
    assign done_o = beat_vld_i && !clr_i && (beat_q == 3'(DESC_WORDS - 1));

endmodule

// File: rtl/dma_desc_fetch.sv
// Walks a linked list of 32-byte descriptors over AVMM burst reads and pushes each to the processor FIFO.
// Latency: doorbell to read request 1 cycle; last beat to FIFO push 2 cycles when not throttled.
// Backpressure: pushes wait while almost_full is high; an accepted burst is always drained.
module dma_desc_fetch
    import dma_desc_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,          // asynchronous, active low
    input  logic [31:0]       csr_control_i,
    input  logic [31:0]       csr_desc_base_i,
    input  logic              csr_desc_start_i,
    output logic              dma_desc_rd_o,
    output logic [ADDR_W-1:0] dma_desc_addr_o,
    output logic [3:0]        dma_desc_burstcount_o,
    input  logic              dma_desc_wait_rq_i,
    input  logic [31:0]       dma_desc_rddata_i,
    input  logic              dma_desc_rddatavalid_i,
    output logic              dma_desc_fifo_wr_o,
    output logic [255:0]      dma_desc_fifo_wrdata_o,
    input  logic              dma_desc_fifo_almost_full_i,
    output logic              dma_desc_fetch_busy_o,
    output logic              dma_desc_fetch_err_o,
    output logic [15:0]       dma_desc_fetch_count_o
);

    fetch_state_e      state_q, state_d;
    logic              rd_q, rd_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [3:0]        burst_q;
    logic              wr_q, wr_d;
    logic [255:0]      wrdata_q, wrdata_d;
    logic              err_q, err_d;
    logic [15:0]       cnt_q, cnt_d;
    logic              busy_q;

    logic              run;
    logic              unused_ctrl;
    logic [255:0]      desc;
    logic              beat_done;
    logic [31:0]       ctrl_w;
    logic [31:0]       next_w;

    assign run         = csr_control_i[0];
    assign unused_ctrl = ^csr_control_i[31:1];
    assign ctrl_w      = desc_word(desc, W_CTRL);
    assign next_w      = desc_word(desc, W_NEXT);

    // Beat slots are rewound while a request is outstanding; beats outside DATA never land.
    dma_desc_beat_asm u_beat_asm (
        .clk        (clk),
        .reset      (reset),
        .clr_i      (state_q == ST_REQ),
        .beat_vld_i (dma_desc_rddatavalid_i && (state_q == ST_DATA)),
        .beat_dat_i (dma_desc_rddata_i),
        .desc_o     (desc),
        .done_o     (beat_done)
    );

    // Next-state and registered-output decode; a push is committed one cycle before wr shows.
    always_comb begin
        state_d  = state_q;
        rd_d     = rd_q;
        addr_d   = addr_q;
        wr_d     = 1'b0;
        wrdata_d = wrdata_q;
        err_d    = err_q;
        cnt_d    = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (csr_desc_start_i && run) begin
                    if (csr_desc_base_i[4:0] != 5'd0) begin
                        err_d = 1'b1;
                    end else begin
                        addr_d  = ADDR_W'(csr_desc_base_i);
                        cnt_d   = '0;
                        err_d   = 1'b0;
                        rd_d    = 1'b1;
                        state_d = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                // Acceptance wins over a simultaneous run drop: the burst is then owed to us.
                if (!dma_desc_wait_rq_i) begin
                    rd_d    = 1'b0;
                    state_d = ST_DATA;
                end else if (!run) begin
                    rd_d    = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (beat_done) begin
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (!ctrl_w[OWNED] || !run) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_PUSH;
                    if (!dma_desc_fifo_almost_full_i) begin
                        wr_d     = 1'b1;
                        wrdata_d = desc;
                        cnt_d    = cnt_q + 16'd1;
                    end
                end
            end
            ST_PUSH: begin
                if (wr_q) begin
                    // The push is on the bus this cycle; decide where the chain goes.
                    if (ctrl_w[EOC]) begin
                        state_d = ST_IDLE;
                    end else if (next_w[4:0] != 5'd0) begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end else if (!run) begin
                        state_d = ST_IDLE;
                    end else begin
                        addr_d  = ADDR_W'(next_w);
                        rd_d    = 1'b1;
                        state_d = ST_REQ;
                    end
                end else if (!run) begin
                    state_d = ST_IDLE;
                end else if (!dma_desc_fifo_almost_full_i) begin
                    wr_d     = 1'b1;
                    wrdata_d = desc;
                    cnt_d    = cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                rd_d    = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            rd_q     <= 1'b0;
            addr_q   <= '0;
            burst_q  <= 4'(DESC_WORDS);
            wr_q     <= 1'b0;
            wrdata_q <= '0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            rd_q     <= rd_d;
            addr_q   <= addr_d;
            burst_q  <= 4'(DESC_WORDS);
            wr_q     <= wr_d;
            wrdata_q <= wrdata_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
            busy_q   <= (state_d != ST_IDLE);
        end
    end

    assign dma_desc_rd_o          = rd_q;
    assign dma_desc_addr_o        = addr_q;
    assign dma_desc_burstcount_o  = burst_q;
    assign dma_desc_fifo_wr_o     = wr_q;
    assign dma_desc_fifo_wrdata_o = wrdata_q;
    assign dma_desc_fetch_busy_o  = busy_q;
    assign dma_desc_fetch_err_o   = err_q;
    assign dma_desc_fetch_count_o = cnt_q;

endmodule

// File: tb/tb_dma_desc_fetch.sv
// Scoreboarded bench for dma_desc_fetch: memory-backed AVMM slave, linked-list reference walk, push monitor.
// Latency: checks the doorbell-to-read and almost_full-release-to-push timing directly.
// Backpressure: drives almost_full both as directed holds and as random toggling.
module tb_dma_desc_fetch;

    logic         clk = 1'b0;
    logic         reset;
    logic [31:0]  csr_control;
    logic [31:0]  csr_base;
    logic         csr_start;
    logic         rd;
    logic [31:0]  addr;
    logic [3:0]   burst;
    logic         wait_rq;
    logic [31:0]  rddata;
    logic         rddatavalid;
    logic         fifo_wr;
    logic [255:0] wrdata;
    logic         af;
    logic         busy;
    logic         err;
    logic [15:0]  count;

    always #5 clk = ~clk;

    dma_desc_fetch dut (
        .clk                         (clk),
        .reset                       (reset),
        .csr_control_i               (csr_control),
        .csr_desc_base_i             (csr_base),
        .csr_desc_start_i            (csr_start),
        .dma_desc_rd_o               (rd),
        .dma_desc_addr_o             (addr),
        .dma_desc_burstcount_o       (burst),
        .dma_desc_wait_rq_i          (wait_rq),
        .dma_desc_rddata_i           (rddata),
        .dma_desc_rddatavalid_i      (rddatavalid),
        .dma_desc_fifo_wr_o          (fifo_wr),
        .dma_desc_fifo_wrdata_o      (wrdata),
        .dma_desc_fifo_almost_full_i (af),
        .dma_desc_fetch_busy_o       (busy),
        .dma_desc_fetch_err_o        (err),
        .dma_desc_fetch_count_o      (count)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [255:0] mem [logic [31:0]];
    logic [31:0]  exp_rd  [$];
    logic [255:0] exp_dat [$];
    logic [15:0]  exp_cnt [$];
    logic [31:0]  beat_q  [$];
    logic         exp_err   = 1'b0;
    logic [15:0]  exp_count = 16'd0;

    int           beat_cnt  = 0;
    int           push_seen = 0;
    logic [255:0] last_push = '0;
    bit           stall_en = 0, gap_en = 0, af_rand = 0, stray_en = 0;
    logic         af_force = 1'b0, wait_force = 1'b0, af_last = 1'b0;

    function automatic void chk(input string name, input logic [255:0] act, input logic [255:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endfunction

    // Reference walk of the descriptor list straight from the layout rules.
    task automatic model_start(input logic [31:0] base);
        logic [31:0]  a;
        logic [31:0]  nxt;
        logic [255:0] d;
        if (base[4:0] != 5'd0) begin
            exp_err = 1'b1;
            return;
        end
        exp_err   = 1'b0;
        exp_count = 16'd0;
        a = base;
        for (int guard = 0; guard < 64; guard++) begin
            exp_rd.push_back(a);
            if (!mem.exists(a)) break;
            d = mem[a];
            if (!d[3*32+31]) break;
            exp_count++;
            exp_dat.push_back(d);
            exp_cnt.push_back(exp_count);
            if (d[3*32+1]) break;
            nxt = d[4*32 +: 32];
            if (nxt[4:0] != 5'd0) begin
                exp_err = 1'b1;
                break;
            end
            a = nxt;
        end
    endtask

    function automatic logic [255:0] make_desc(input logic [31:0] w3, input logic [31:0] w4);
        logic [255:0] d;
        for (int j = 0; j < 8; j++) d[32*j +: 32] = $urandom;
        d[3*32 +: 32] = w3;
        d[4*32 +: 32] = w4;
        return d;
    endfunction

    // AVMM slave and almost_full driver: inputs change 1 time unit after the rising edge.
    initial begin
        wait_rq = 1'b0; rddata = '0; rddatavalid = 1'b0; af = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            wait_rq = stall_en ? ($urandom_range(0, 2) == 0) : wait_force;
            af      = af_rand ? ($urandom_range(0, 2) == 0) : af_force;
            if (beat_q.size() > 0) begin
                if (gap_en && $urandom_range(0, 3) == 0) begin
                    rddatavalid = 1'b0;
                    rddata      = $urandom;
                end else begin
                    rddatavalid = 1'b1;
                    rddata      = beat_q.pop_front();
                    beat_cnt++;
                end
            end else begin
                rddatavalid = stray_en && ($urandom_range(0, 7) == 0);
                rddata      = $urandom;
            end
        end
    end

    // Monitor: scores read acceptances and FIFO pushes against the expected queues.
    initial begin
        logic [255:0] d;
        forever begin
            @(negedge clk);
            if (reset) begin
                if (rd && !wait_rq) begin
                    chk("burstcount", 256'(burst), 256'(8));
                    if (exp_rd.size() == 0) begin
                        n_checks++; n_fail++;
                        $display("FAIL unexpected_read: got addr %0h expected no read", addr);
                    end else begin
                        chk("read_addr", 256'(addr), 256'(exp_rd.pop_front()));
                    end
                    d = mem.exists(addr) ? mem[addr] : '0;
                    for (int i = 0; i < 8; i++) beat_q.push_back(d[32*i +: 32]);
                    beat_cnt = 0;
                end
                if (fifo_wr) begin
                    chk("push_while_almost_full", 256'(af_last), 256'(0));
                    if (exp_dat.size() == 0) begin
                        n_checks++; n_fail++;
                        $display("FAIL unexpected_push: got data %0h expected no push", wrdata);
                    end else begin
                        chk("push_data", wrdata, exp_dat.pop_front());
                        chk("push_count", 256'(count), 256'(exp_cnt.pop_front()));
                    end
                    last_push = wrdata;
                    push_seen++;
                end
            end
            af_last = af;
        end
    end

    task automatic doorbell(input logic [31:0] base, input logic expect_rd);
        @(posedge clk); #1;
        csr_base  = base;
        csr_start = 1'b1;
        @(posedge clk); #1;
        csr_start = 1'b0;
        chk("rd_after_doorbell", 256'(rd), 256'(expect_rd));
    endtask

    task automatic wait_idle(input string name);
        int t;
        for (t = 0; t < 3000; t++) begin
            @(negedge clk);
            if (!busy && beat_q.size() == 0) break;
        end
        chk({name, "_idle_timeout"}, 256'(t >= 3000), 256'(0));
    endtask

    task automatic wait_beats(input int n);
        int t;
        for (t = 0; t < 500; t++) begin
            @(negedge clk);
            if (beat_cnt >= n && beat_q.size() <= 8 - n) break;
        end
        chk("beat_wait_timeout", 256'(t >= 500), 256'(0));
    endtask

    task automatic end_checks(input string name);
        chk({name, "_reads_left"}, 256'(exp_rd.size()), 256'(0));
        chk({name, "_pushes_left"}, 256'(exp_dat.size()), 256'(0));
        chk({name, "_err"}, 256'(err), 256'(exp_err));
        chk({name, "_count"}, 256'(count), 256'(exp_count));
        exp_rd.delete();
        exp_dat.delete();
        exp_cnt.delete();
    endtask

    task automatic build_chain(input int n, input int kind, output logic [31:0] base);
        logic [31:0]  region;
        logic [255:0] d;
        region = $urandom & 32'h0FFF_F000;
        mem.delete();
        for (int i = 0; i < n; i++) begin
            d = make_desc($urandom, region | 32'((i + 1) << 6));
            d[3*32+31] = 1'b1;
            d[3*32+1]  = 1'b0;
            if (i == n - 1) begin
                if (kind == 0) begin
                    d[3*32+1] = 1'b1;
                end else if (kind == 1) begin
                    d[3*32+31] = 1'b0;
                end else begin
                    d[4*32 +: 32] = region | 32'((i + 1) << 6) | 32'($urandom_range(1, 31));
                end
            end
            mem[region | 32'(i << 6)] = d;
        end
        base = region;
    endtask

    initial begin
        int           pushes0;
        int           t;
        logic [31:0]  base;

        #3_000_000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1);
    end

    initial begin
        int           pushes0;
        int           t;
        logic [31:0]  base;

        reset = 1'b0; csr_control = 32'h1; csr_base = '0; csr_start = 1'b0;
        repeat (3) @(negedge clk);
        // Reset values.
        chk("reset_rd", 256'(rd), 256'(0));
        chk("reset_addr", 256'(addr), 256'(0));
        chk("reset_burst", 256'(burst), 256'(8));
        chk("reset_wr", 256'(fifo_wr), 256'(0));
        chk("reset_wrdata", wrdata, 256'(0));
        chk("reset_busy", 256'(busy), 256'(0));
        chk("reset_err", 256'(err), 256'(0));
        chk("reset_count", 256'(count), 256'(0));
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Single descriptor.
        mem[32'h1000] = make_desc(32'h8000_0002, 32'h0);
        pushes0 = push_seen;
        model_start(32'h1000);
        doorbell(32'h1000, 1'b1);
        wait_idle("single");
        end_checks("single");
        chk("single_push_num", 256'(push_seen - pushes0), 256'(1));
        chk("single_w3", 256'(last_push[127:96]), 256'(32'h8000_0002));

        // Chain of three, with an ignored doorbell while busy.
        mem[32'h2000] = make_desc(32'h8000_0000, 32'h2020);
        mem[32'h2020] = make_desc(32'h8000_0001, 32'h2040);
        mem[32'h2040] = make_desc(32'h8000_0002, 32'h0);
        model_start(32'h2000);
        doorbell(32'h2000, 1'b1);
        repeat (3) @(posedge clk);
        #1; csr_base = 32'h9000; csr_start = 1'b1;
        @(posedge clk); #1; csr_start = 1'b0;
        wait_idle("chain3");
        end_checks("chain3");

        // Backpressure held for 20 cycles after the last beat.
        mem[32'h5000] = make_desc(32'h8000_0002, 32'h0);
        @(negedge clk); af_force = 1'b1;
        model_start(32'h5000);
        doorbell(32'h5000, 1'b1);
        wait_beats(8);
        pushes0 = push_seen;
        repeat (20) @(negedge clk);
        chk("bp_no_push", 256'(push_seen - pushes0), 256'(0));
        af_force = 1'b0;
        for (t = 0; t < 4; t++) begin
            @(negedge clk);
            if (!af) break;
        end
        chk("bp_wr_same_cycle", 256'(fifo_wr), 256'(0));
        @(negedge clk);
        chk("bp_wr_next_cycle", 256'(fifo_wr), 256'(1));
        wait_idle("bp");
        end_checks("bp");

        // Unowned second descriptor.
        mem[32'h3000] = make_desc(32'h8000_0000, 32'h3020);
        mem[32'h3020] = make_desc(32'h0000_0000, 32'h3040);
        mem[32'h3040] = make_desc(32'h8000_0002, 32'h0);
        model_start(32'h3000);
        doorbell(32'h3000, 1'b1);
        wait_idle("unowned");
        end_checks("unowned");

        // Misaligned next pointer, then misaligned doorbell.
        mem[32'h4000] = make_desc(32'h8000_0000, 32'h2004);
        model_start(32'h4000);
        doorbell(32'h4000, 1'b1);
        wait_idle("bad_next");
        end_checks("bad_next");
        model_start(32'h1010);
        doorbell(32'h1010, 1'b0);
        repeat (5) @(negedge clk);
        wait_idle("bad_base");
        end_checks("bad_base");

        // Run dropped after beat 3: burst drained, nothing pushed, err cleared by the doorbell.
        mem[32'h6000] = make_desc(32'h8000_0002, 32'h0);
        exp_rd.push_back(32'h6000); exp_err = 1'b0; exp_count = 16'd0;
        pushes0 = push_seen;
        doorbell(32'h6000, 1'b1);
        wait_beats(3);
        csr_control = 32'h0;
        wait_idle("run_drop");
        end_checks("run_drop");
        chk("run_drop_no_push", 256'(push_seen - pushes0), 256'(0));
        csr_control = 32'h1;

        // Run dropped in REQ before acceptance.
        @(negedge clk); wait_force = 1'b1;
        doorbell(32'h6000, 1'b1);
        repeat (4) @(negedge clk);
        csr_control = 32'h0;
        wait_idle("req_drop");
        chk("req_drop_rd", 256'(rd), 256'(0));
        end_checks("req_drop");
        wait_force = 1'b0;
        csr_control = 32'h1;

        // Async reset during the second burst of a chain.
        mem[32'h7000] = make_desc(32'h8000_0000, 32'h7020);
        mem[32'h7020] = make_desc(32'h8000_0002, 32'h0);
        model_start(32'h7000);
        doorbell(32'h7000, 1'b1);
        for (t = 0; t < 500; t++) begin
            @(negedge clk);
            if (exp_rd.size() == 0 && beat_cnt >= 2) break;
        end
        chk("rst_wait_timeout", 256'(t >= 500), 256'(0));
        @(posedge clk); #2;
        reset = 1'b0;
        #1;
        chk("arst_rd", 256'(rd), 256'(0));
        chk("arst_addr", 256'(addr), 256'(0));
        chk("arst_burst", 256'(burst), 256'(8));
        chk("arst_wr", 256'(fifo_wr), 256'(0));
        chk("arst_wrdata", wrdata, 256'(0));
        chk("arst_busy", 256'(busy), 256'(0));
        chk("arst_err", 256'(err), 256'(0));
        chk("arst_count", 256'(count), 256'(0));
        @(negedge clk);
        beat_q.delete(); exp_rd.delete(); exp_dat.delete(); exp_cnt.delete();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        exp_err = 1'b0; exp_count = 16'd0;

        // Randomized chains under stalls, beat gaps, stray beats and almost_full noise.
        stall_en = 1; gap_en = 1; af_rand = 1; stray_en = 1;
        for (int it = 0; it < 20; it++) begin
            build_chain($urandom_range(1, 5), $urandom_range(0, 2), base);
            if ($urandom_range(0, 5) == 0) base = base | 32'h8;
            model_start(base);
            doorbell(base, base[4:0] == 5'd0);
            wait_idle("rand");
            end_checks("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
